// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and op classification helpers.
package mdu_pkg;

    // Op codes presented on the op port
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // True for the two divide ops
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // True for any op that starts an operation; the rest are no-ops
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) ||
               (op == OP_DIV)   || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider. On load it latches the operand magnitudes and
// the result signs, then produces one quotient bit per cycle for WIDTH
// cycles. done is high during the cycle whose closing edge performs the
// final iteration, so quotient/remainder are final on the following cycle
// and stay stable until the next load.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    cnt_reg;
    logic             run_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Operand magnitudes and one restoring step; the borrow bit of the trial
    // subtraction decides whether the shifted remainder is restored.
    always_comb begin
        a_neg    = signed_op & dividend[WIDTH-1];
        b_neg    = signed_op & divisor[WIDTH-1];
        abs_a    = a_neg ? (~dividend + 1'b1) : dividend;
        abs_b    = b_neg ? (~divisor + 1'b1) : divisor;
        trial    = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};
        take     = ~trial[WIDTH];
        rem_next = take ? trial[WIDTH-1:0] : {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
        quo_next = {quo_reg[WIDTH-2:0], take};
    end

    // Load operands, then iterate until the last quotient bit is shifted in
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (load) begin
            rem_reg   <= '0;
            quo_reg   <= abs_a;
            dvs_reg   <= abs_b;
            cnt_reg   <= '0;
            run_reg   <= 1'b1;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
        end else if (run_reg) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
                run_reg <= 1'b0;
            end
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend sign.
    // MIN / -1 wraps naturally to MIN with a zero remainder.
    always_comb begin
        done      = run_reg && (cnt_reg == LAST);
        quotient  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
        remainder = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO. Multiplies complete MUL_LAT cycles
// after the start edge, divides WIDTH+1 cycles after it. A direct HI/LO
// write always lands and aborts any operation in flight.
// Optional build macro MDU_DIV0_FLAG_EN adds a one-cycle div0 pulse output
// for an accepted divide whose divisor is zero.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
`ifdef MDU_DIV0_FLAG_EN
    output logic             busy,
    output logic             div0
`else
    output logic             busy
`endif
);

    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [1:0]         state_reg, state_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [MCW-1:0]     mul_cnt_reg;

    logic               accept;
    logic               div_by_zero;
    logic               go;
    logic               div_load;
    logic               div_done;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;

    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;

    // Issue qualification: a direct write always wins over start
    always_comb begin
        accept      = (state_reg == ST_IDLE) && start && !hilo_we && is_valid_op(op);
        div_by_zero = is_div(op) && (src_b == '0);
        go          = accept && !div_by_zero;
        div_load    = go && is_div(op);
    end

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (src_a),
        .divisor   (src_b),
        .signed_op (op == OP_DIV),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Full-width product from the latched operands; sign-extending to 2*WIDTH
    // makes the low half of one unsigned multiply serve both signednesses.
    always_comb begin
        mul_signed = (op_reg != OP_MULTU);
        ext_a      = {{WIDTH{mul_signed & a_reg[WIDTH-1]}}, a_reg};
        ext_b      = {{WIDTH{mul_signed & b_reg[WIDTH-1]}}, b_reg};
        prod       = ext_a * ext_b;
        case (op_reg)
            OP_MADD: mul_res = acc_reg + prod;
            OP_MSUB: mul_res = acc_reg - prod;
            default: mul_res = prod;
        endcase
    end

    // FSM next state and HI/LO update
    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go) begin
                    if (is_div(op)) begin
                        state_next = ST_DIV;
                    end else begin
                        state_next = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (int'(mul_cnt_reg) >= MUL_LAT - 2) begin
                    state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (is_div(op_reg)) begin
                    hi_next = div_r;
                    lo_next = div_q;
                end else begin
                    hi_next = mul_res[2*WIDTH-1:WIDTH];
                    lo_next = mul_res[WIDTH-1:0];
                end
            end
        endcase
        // A direct write aborts whatever is in flight, including a pending
        // result write for the other half.
        if (hilo_we) begin
            state_next = ST_IDLE;
            hi_next    = hilo_sel ? hi_reg : wdata;
            lo_next    = hilo_sel ? wdata : lo_reg;
        end
    end

    // State and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // Operand capture at issue; accumulate base is {hi,lo} at the start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg  <= OP_MULTU;
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
        end else if (go) begin
            op_reg  <= op;
            a_reg   <= src_a;
            b_reg   <= src_b;
            acc_reg <= {hi_reg, lo_reg};
        end
    end

    // Multiply latency counter, idle at zero outside MUL
    always_ff @(posedge clk) begin
        if (reset || (state_reg != ST_MUL)) begin
            mul_cnt_reg <= '0;
        end else begin
            mul_cnt_reg <= mul_cnt_reg + 1'b1;
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    logic div0_reg;

    // One-cycle flag for a rejected divide-by-zero issue
    always_ff @(posedge clk) begin
        if (reset) begin
            div0_reg <= 1'b0;
        end else begin
            div0_reg <= accept && div_by_zero;
        end
    end

    assign div0 = div0_reg;
`endif

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter with hand-computed expected HI/LO values,
// latencies, abort and reset behaviour. Build with MDU_DIV0_FLAG_EN defined
// to also exercise the div0 pulse.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         hilo_we;
    logic         hilo_sel;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
`ifdef MDU_DIV0_FLAG_EN
    logic         div0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(
        .WIDTH   (W),
        .MUL_LAT (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
`ifdef MDU_DIV0_FLAG_EN
        .busy     (busy),
        .div0     (div0)
`else
        .busy     (busy)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns #1 after that edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic write_hilo(input logic sel, input logic [W-1:0] d);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        wdata    = d;
        tick();
        hilo_we  = 1'b0;
    endtask

    // Count cycles busy stays high (including the first), bounded
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'b000;
        src_a    = '0;
        src_b    = '0;
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        wdata    = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);

        // multu 0xFFFFFFFF * 2
        issue(3'b000, 32'hFFFF_FFFF, 32'd2);
        check("multu_busy_rise", busy, 1);
        wait_idle(cyc);
        check("multu_latency", cyc, 5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // mult -3 * 5 = -15
        issue(3'b001, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // div -7 / 2 -> q=-3, r=-1
        issue(3'b011, 32'hFFFF_FFF9, 32'd2);
        check("div_busy_rise", busy, 1);
        wait_idle(cyc);
        check("div_latency", cyc, 33);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        // div MIN / -1 wraps
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'h0000_0000);

        // divu 100 / 7 -> q=14, r=2
        issue(3'b010, 32'd100, 32'd7);
        wait_idle(cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // madd / msub accumulate onto {hi,lo}
        write_hilo(1'b0, 32'd0);
        write_hilo(1'b1, 32'd10);
        check("preload_hi", hi, 0);
        check("preload_lo", lo, 10);
        issue(3'b101, 32'd3, 32'd4);
        wait_idle(cyc);
        check("madd_lo", lo, 22);
        check("madd_hi", hi, 0);
        issue(3'b110, 32'd0, 32'd5);
        wait_idle(cyc);
        check("msub0_lo", lo, 22);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1);
        wait_idle(cyc);
        check("msub_neg_lo", lo, 23);
        check("msub_neg_hi", hi, 0);

        // divu by zero is dropped
        issue(3'b010, 32'd9, 32'd0);
        check("div0_busy", busy, 0);
`ifdef MDU_DIV0_FLAG_EN
        check("div0_pulse", div0, 1);
        tick();
        check("div0_pulse_end", div0, 0);
`endif
        tick();
        check("div0_busy_later", busy, 0);
        check("div0_hi", hi, 0);
        check("div0_lo", lo, 23);

        // invalid op is ignored
        issue(3'b100, 32'd3, 32'd3);
        check("invalid_busy", busy, 0);

        // abort a divide with a direct LO write on its 4th busy cycle
        write_hilo(1'b0, 32'h1234);
        issue(3'b010, 32'd100, 32'd7);      // busy cycle 1
        tick();                              // busy cycle 2
        issue(3'b000, 32'd5, 32'd5);        // start while busy; now cycle 3
        check("busy_start_ignored", busy, 1);
        tick();                              // busy cycle 4
        write_hilo(1'b1, 32'h55);
        check("abort_lo", lo, 32'h55);
        check("abort_hi", hi, 32'h1234);
        check("abort_busy", busy, 0);
        repeat (40) tick();
        check("abort_no_late_lo", lo, 32'h55);
        check("abort_no_late_hi", hi, 32'h1234);

        // write and start in the same cycle: write wins, start ignored
        hilo_we  = 1'b1;
        hilo_sel = 1'b1;
        wdata    = 32'h77;
        issue(3'b000, 32'd6, 32'd7);
        hilo_we  = 1'b0;
        check("we_start_busy", busy, 0);
        check("we_start_lo", lo, 32'h77);
        repeat (8) tick();
        check("we_start_no_mul", lo, 32'h77);

        // reset during cycle 10 of a divide
        issue(3'b011, 32'd1000, 32'd3);     // busy cycle 1
        repeat (9) tick();                   // busy cycle 10
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_busy", busy, 0);
        repeat (40) tick();
        check("midreset_no_late_lo", lo, 0);
        check("midreset_no_late_hi", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
